// File: rtl/rf_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_ctrl
// Description : Write-back controller for the 32 x XLEN integer register file.
//               Merges single-cycle execute results (port A) with buffered
//               long-latency results (port B) into one registered write port,
//               and tracks pending long-latency destinations in a scoreboard.
// Ports       : clk, rst (async, active-high)
//               a_valid/a_rd/a_data          execute-pipe result, no backpressure
//               b_valid/b_ready/b_rd/b_data  long-latency result, valid/ready
//               issue_valid/issue_rd         long-latency op issued by decode
//               rs1_index/rs2_index -> rs1_busy/rs2_busy  scoreboard lookup
//               wb_en/rd_index/wb_data       registered register-file write port
// Options     : `define WB_FWD_EN adds rs1/rs2_fwd_hit and rs1/rs2_fwd_data,
//               a combinational bypass of the write port for decode reads.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_index,
    input  logic [4:0]      rs2_index,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wb_en,
    output logic [4:0]      rd_index,
    output logic [XLEN-1:0] wb_data
`ifdef WB_FWD_EN
    ,
    output logic            rs1_fwd_hit,
    output logic            rs2_fwd_hit,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic [XLEN-1:0] rs2_fwd_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);

    // Port-B result FIFO storage (no reset needed; validity comes from r_count)
    logic [4:0]      r_mem_rd   [DEPTH];
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic [31:0]     r_sb;
    logic [31:0]     w_sb_next;

    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;

    assign b_ready     = (r_count != c_CNT_FULL);
    assign w_push      = b_valid && b_ready;
    // A owns the write port whenever it is valid; the FIFO only drains on idle A cycles.
    assign w_pop       = !a_valid && (r_count != '0);
    assign w_head_rd   = r_mem_rd[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= b_rd;
            r_mem_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: results for x0 are consumed but never raise wb_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en    <= 1'b0;
            rd_index <= '0;
            wb_data  <= '0;
        end else if (a_valid) begin
            wb_en    <= (a_rd != 5'd0);
            rd_index <= a_rd;
            wb_data  <= a_data;
        end else if (w_pop) begin
            wb_en    <= (w_head_rd != 5'd0);
            rd_index <= w_head_rd;
            wb_data  <= w_head_data;
        end else begin
            wb_en    <= 1'b0;
        end
    end

    // Scoreboard: clear on pop first, then apply issue so a same-cycle set wins.
    always_comb begin
        w_sb_next = r_sb;
        if (w_pop) begin
            w_sb_next[w_head_rd] = 1'b0;
        end
        if (issue_valid) begin
            w_sb_next[issue_rd] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    assign rs1_busy = r_sb[rs1_index];
    assign rs2_busy = r_sb[rs2_index];

`ifdef WB_FWD_EN
    assign rs1_fwd_hit  = wb_en && (rd_index == rs1_index) && (rs1_index != 5'd0);
    assign rs2_fwd_hit  = wb_en && (rd_index == rs2_index) && (rs2_index != 5'd0);
    assign rs1_fwd_data = wb_data;
    assign rs2_fwd_data = wb_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_ctrl
// Description : Directed self-checking bench for rf_wb_ctrl (DEPTH=4, XLEN=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [63:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [63:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_en;
    logic [4:0]  rd_index;
    logic [63:0] wb_data;
`ifdef WB_FWD_EN
    logic        rs1_fwd_hit;
    logic        rs2_fwd_hit;
    logic [63:0] rs1_fwd_data;
    logic [63:0] rs2_fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rf_wb_ctrl #(.DEPTH(4), .XLEN(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_index   (rs1_index),
        .rs2_index   (rs2_index),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wb_en       (wb_en),
        .rd_index    (rd_index),
        .wb_data     (wb_data)
`ifdef WB_FWD_EN
        ,
        .rs1_fwd_hit (rs1_fwd_hit),
        .rs2_fwd_hit (rs2_fwd_hit),
        .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before checking/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [63:0] d);
        chk({tag, ".wb_en"},    64'(wb_en),    64'(en));
        chk({tag, ".rd_index"}, 64'(rd_index), 64'(rd));
        chk({tag, ".wb_data"},  wb_data,       d);
    endtask

    initial begin
        rst = 1'b1; a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0; rs1_index = 0; rs2_index = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk_wb("reset", 1'b0, 5'd0, 64'h0);
        chk("reset.b_ready", 64'(b_ready), 64'd1);
        chk("reset.rs1_busy", 64'(rs1_busy), 64'd0);

        // A only: one-cycle latency, then idle drops wb_en and holds index/data
        a_valid = 1; a_rd = 5; a_data = 64'h1234; rs1_index = 5;
        tick();
        a_valid = 0;
        chk_wb("a_only", 1'b1, 5'd5, 64'h1234);
`ifdef WB_FWD_EN
        chk("fwd.hit",  64'(rs1_fwd_hit), 64'd1);
        chk("fwd.data", rs1_fwd_data, 64'h1234);
`endif
        tick();
        chk_wb("a_idle", 1'b0, 5'd5, 64'h1234);

        // Priority: B accepted, then A in the next cycle wins the port
        b_valid = 1; b_rd = 7; b_data = 64'hAA;
        tick();
        b_valid = 0; a_valid = 1; a_rd = 3; a_data = 64'hBB;
        tick();
        a_valid = 0;
        chk_wb("prio.a", 1'b1, 5'd3, 64'hBB);
        tick();
        chk_wb("prio.b", 1'b1, 5'd7, 64'hAA);
        tick();
        chk("prio.idle", 64'(wb_en), 64'd0);

        // Scoreboard set/clear on rd 9
        rs1_index = 9; rs2_index = 9;
        issue_valid = 1; issue_rd = 9;
        chk("sb.same_cycle_issue", 64'(rs1_busy), 64'd0);
        tick();
        issue_valid = 0;
        chk("sb.set.rs1", 64'(rs1_busy), 64'd1);
        chk("sb.set.rs2", 64'(rs2_busy), 64'd1);
        b_valid = 1; b_rd = 9; b_data = 64'h99;
        tick();
        b_valid = 0;
        chk("sb.pending", 64'(rs1_busy), 64'd1);
        tick();
        chk_wb("sb.pop", 1'b1, 5'd9, 64'h99);
        chk("sb.cleared", 64'(rs1_busy), 64'd0);

        // Same-cycle issue and pop of rd 9: set wins
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0; b_valid = 1; b_rd = 9; b_data = 64'h98;
        tick();
        b_valid = 0; issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        chk_wb("sb.setwin.pop", 1'b1, 5'd9, 64'h98);
        chk("sb.setwin", 64'(rs1_busy), 64'd1);
        b_valid = 1; b_rd = 9; b_data = 64'h97;
        tick();
        b_valid = 0;
        tick();
        chk("sb.final_clear", 64'(rs2_busy), 64'd0);

        // Full FIFO with A holding the port
        a_valid = 1; a_rd = 1; a_data = 64'h11;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1; b_rd = 5'(10 + i); b_data = 64'hB0 + 64'(i);
            if (i == 3) chk("full.ready_before_4th", 64'(b_ready), 64'd1);
            tick();
        end
        chk("full.ready", 64'(b_ready), 64'd0);
        chk_wb("full.a_holds", 1'b1, 5'd1, 64'h11);
        b_rd = 14; b_data = 64'hEE;   // offered while full: must not be taken
        tick();
        chk("full.still", 64'(b_ready), 64'd0);
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wb($sformatf("full.drain%0d", i), 1'b1, 5'(10 + i), 64'hB0 + 64'(i));
            chk($sformatf("full.ready%0d", i), 64'(b_ready), 64'd1);
        end
        tick();
        chk("full.empty", 64'(wb_en), 64'd0);

        // x0 results and issue to x0
        a_valid = 1; a_rd = 0; a_data = 64'h55;
        tick();
        a_valid = 0;
        chk("x0.a", 64'(wb_en), 64'd0);
        b_valid = 1; b_rd = 0; b_data = 64'h66;
        issue_valid = 1; issue_rd = 0; rs1_index = 0;
        tick();
        b_valid = 0; issue_valid = 0;
        chk("x0.b_push", 64'(wb_en), 64'd0);
        chk("x0.busy", 64'(rs1_busy), 64'd0);
        tick();
        chk_wb("x0.b_pop", 1'b0, 5'd0, 64'h66);

        // Reset mid-stream with 3 queued B results and a pending rd
        issue_valid = 1; issue_rd = 20; rs1_index = 20;
        a_valid = 1; a_rd = 2; a_data = 64'h22;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1; b_rd = 5'(21 + i); b_data = 64'hC0 + 64'(i);
            tick();
            issue_valid = 0;
        end
        b_valid = 0;
        chk("mid.busy_before", 64'(rs1_busy), 64'd1);
        chk("mid.wb_before", 64'(wb_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid.wb_en", 64'(wb_en), 64'd0);
        chk("mid.b_ready", 64'(b_ready), 64'd1);
        for (int i = 0; i < 32; i++) begin
            rs1_index = 5'(i);
            #0.1;
            chk($sformatf("mid.busy%0d", i), 64'(rs1_busy), 64'd0);
        end
        tick();
        rst = 1'b0; a_valid = 0;
        tick();
        chk("mid.discarded", 64'(wb_en), 64'd0);
        tick();
        chk("mid.discarded2", 64'(wb_en), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Writer-side controller for the 32x64 integer register file. Merges results from the single-cycle execute pipe (port A) and the long-latency load/multiply unit (port B) into the register file's single write port (wb_en / rd_index / wb_data). Buffers port-B results in a small FIFO and keeps a pending-destination scoreboard so decode can stall on outstanding long-latency writes.

Parameters:
DEPTH, 4, port-B result FIFO entries; power of 2, minimum 2.
XLEN, 64, data width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
a_valid  in  1  execute-pipe result valid this cycle; no backpressure.
a_rd  in  5  execute-pipe destination.
a_data  in  XLEN  execute-pipe result.
b_valid  in  1  long-latency result valid.
b_ready  out  1  FIFO can accept; combinational, equals not-full.
b_rd  in  5  long-latency destination.
b_data  in  XLEN  long-latency result.
issue_valid  in  1  decode issued a long-latency op this cycle.
issue_rd  in  5  its destination.
rs1_index  in  5  decode source 1.
rs2_index  in  5  decode source 2.
rs1_busy  out  1  scoreboard bit for rs1_index; combinational.
rs2_busy  out  1  scoreboard bit for rs2_index; combinational.
wb_en  out  1  register-file write enable; registered.
rd_index  out  5  register-file write index; registered.
wb_data  out  XLEN  register-file write data; registered.

Behaviour:
- Reset (async, rst=1): wb_en=0, rd_index=0, wb_data=0, FIFO empty (b_ready=1), all scoreboard bits 0. Reset mid-operation discards buffered results and pending bits.
- Port B accept: b_valid && b_ready at edge t pushes {b_rd, b_data}. b_ready=0 when count==DEPTH. No push when full; B must hold.
- Output select each cycle, in priority order:
  - a_valid: load A into the output regs. A always wins; FIFO does not pop.
  - else FIFO non-empty: pop head into the output regs.
  - else: wb_en<=0; rd_index and wb_data hold.
- Latency:
  - A: 1 cycle (a_valid at t, wb_en at t+1).
  - B: minimum 2 cycles (accepted at t, popped at t+1, wb_en at t+2). Each A cycle adds one cycle of delay.
- Simultaneous push and pop on a full FIFO is not possible because b_ready is already 0. Push and pop in the same cycle keeps the count unchanged. Pointers wrap modulo DEPTH.
- x0 writes: an A or B result with rd==0 is consumed normally, but the output stage loads wb_en=0. wb_en is never 1 with rd_index==0.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - set on issue_valid && issue_rd!=0.
  - cleared when a FIFO pop loads the output regs with that rd.
  - same-cycle set and clear of the same index: set wins.
  - rsN_busy reflects register state, not same-cycle issue.
- Ordering is decode's responsibility: decode stalls on rsN_busy and on destination busy, so A and B never target the same pending rd. This block does not check for it.

Optional Feature:
WB_FWD_EN:
- Defined: adds outputs rs1_fwd_hit, rs2_fwd_hit (1 bit) and rs1_fwd_data, rs2_fwd_data (XLEN).
  - hit = wb_en && rd_index==rsN_index && rsN_index!=0.
  - data = wb_data, combinational.
  - This covers the write-then-read-same-cycle case for decode.
- Undefined: these ports do not exist and decode reads only the register file.

Test Plan:
- Reset mid-stream: 3 B entries queued, rst=1 -> wb_en=0, b_ready=1, rs1_busy=0 for all indices.
- A only: a_valid, a_rd=5, a_data=0x1234 at t -> wb_en=1, rd_index=5, wb_data=0x1234 at t+1; wb_en=0 at t+2 with no input.
- Priority: B {rd=7, 0xAA} accepted at t, a_valid {rd=3, 0xBB} at t+1 -> t+2 writes rd 3, t+3 writes rd 7.
- Full FIFO: a_valid held high, push 4 B results -> b_ready=0 after the 4th. Drop a_valid -> 4 writes in FIFO order on consecutive cycles; b_ready returns 1 one cycle after the first pop.
- Scoreboard: issue_rd=9 -> rs1_busy=1 (rs1_index=9) from the next cycle until the cycle after the rd-9 pop. Same-cycle issue_rd=9 with a pop of rd 9 -> stays 1.
- x0: a_rd=0 and b_rd=0 results, and issue_rd=0 -> wb_en never 1, rs1_busy(0)=0.
